// File: rtl/wallace_mult4.sv
// wallace_mult4 -- registered unsigned 4x4 multiplier.
//
// The 16 partial products are reduced by a two-layer Wallace tree built from
// explicit half/full adder cells. A ripple carry-propagate adder then merges
// the two remaining rows, and the 8-bit result is registered.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset (clears prod)
//   A      in   4  unsigned multiplicand
//   B      in   4  unsigned multiplier
//   prod   out  8  registered product A*B, one cycle after the operands

// Half adder cell: s_o = a_i ^ b_i, co_o = a_i & b_i.
module wallace_mult4_ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i;
    assign co_o = a_i & b_i;
endmodule

// Full adder cell: {co_o, s_o} = a_i + b_i + ci_i.
module wallace_mult4_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

module wallace_mult4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] prod
);
    // pp[i][j] = A[j] & B[i], weight i+j.
    logic [3:0] pp [4];

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            pp[i] = A & {4{B[i]}};
        end
    end

    // Column heights entering the tree (weights 0..6): 1 2 3 4 3 2 1.
    // Layer 1: one cell per column; pp[3][0] passes through column 3.
    logic s1_1, c1_1, s1_2, c1_2, s1_3, c1_3, s1_4, c1_4, s1_5, c1_5;

    wallace_mult4_ha u_ha1_1 (.a_i(pp[0][1]), .b_i(pp[1][0]),
                              .s_o(s1_1), .co_o(c1_1));
    wallace_mult4_fa u_fa1_2 (.a_i(pp[0][2]), .b_i(pp[1][1]), .ci_i(pp[2][0]),
                              .s_o(s1_2), .co_o(c1_2));
    wallace_mult4_fa u_fa1_3 (.a_i(pp[0][3]), .b_i(pp[1][2]), .ci_i(pp[2][1]),
                              .s_o(s1_3), .co_o(c1_3));
    wallace_mult4_fa u_fa1_4 (.a_i(pp[1][3]), .b_i(pp[2][2]), .ci_i(pp[3][1]),
                              .s_o(s1_4), .co_o(c1_4));
    wallace_mult4_ha u_ha1_5 (.a_i(pp[2][3]), .b_i(pp[3][2]),
                              .s_o(s1_5), .co_o(c1_5));

    // Heights after layer 1 (weights 0..6): 1 1 2 3 2 2 2.
    // Layer 2 reduces column 3 with a full adder. Pairs in columns 2, 4, 5
    // and 6 are also halved, otherwise the incoming carries would push those
    // columns back above two bits.
    logic s2_2, c2_2, s2_3, c2_3, s2_4, c2_4, s2_5, c2_5, s2_6, c2_6;

    wallace_mult4_ha u_ha2_2 (.a_i(s1_2), .b_i(c1_1),
                              .s_o(s2_2), .co_o(c2_2));
    wallace_mult4_fa u_fa2_3 (.a_i(s1_3), .b_i(pp[3][0]), .ci_i(c1_2),
                              .s_o(s2_3), .co_o(c2_3));
    wallace_mult4_ha u_ha2_4 (.a_i(s1_4), .b_i(c1_3),
                              .s_o(s2_4), .co_o(c2_4));
    wallace_mult4_ha u_ha2_5 (.a_i(s1_5), .b_i(c1_4),
                              .s_o(s2_5), .co_o(c2_5));
    wallace_mult4_ha u_ha2_6 (.a_i(pp[3][3]), .b_i(c1_5),
                              .s_o(s2_6), .co_o(c2_6));

    // Two rows remain.
    logic [7:0] row0, row1;
    assign row0 = {c2_6, s2_6, s2_5, s2_4, s2_3, s2_2, s1_1, pp[0][0]};
    assign row1 = {1'b0, c2_5, c2_4, c2_3, c2_2, 3'b000};

    // Ripple carry-propagate adder. Bit 7 keeps only its sum: the carry out
    // of bit 7 is always zero because the product is at most 225.
    logic [7:0] carry;
    logic [7:0] sum;

    assign carry[0] = 1'b0;

    for (genvar k = 0; k < 7; k++) begin : g_cpa
        wallace_mult4_fa u_fa (.a_i(row0[k]), .b_i(row1[k]), .ci_i(carry[k]),
                               .s_o(sum[k]), .co_o(carry[k+1]));
    end

    assign sum[7] = row0[7] ^ row1[7] ^ carry[7];

    logic [7:0] prod_d, prod_q;

    assign prod_d = sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign prod = prod_q;

endmodule

// File: tb/tb_wallace_mult4.sv
module tb_wallace_mult4;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] prod;

    int unsigned nchk;
    int unsigned nerr;

    wallace_mult4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .prod  (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: prod=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive operands at the falling edge, check one rising edge later.
    task automatic cycle(input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp, input string tag);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
        chk(tag, prod, exp);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t corners[4] = '{
        '{4'd0,  4'd15, 8'h00},
        '{4'd1,  4'd13, 8'h0D},
        '{4'd15, 4'd15, 8'hE1},
        '{4'd8,  4'd8,  8'h40}
    };

    vec_t b2b[4] = '{
        '{4'd3,  4'd5,  8'd15},
        '{4'd15, 4'd1,  8'd15},
        '{4'd12, 4'd12, 8'd144},
        '{4'd7,  4'd9,  8'd63}
    };

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        nchk  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        A     = 4'hF;
        B     = 4'hF;

        // Held in reset with operands present: prod stays zero across edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold", prod, 8'h00);
        end

        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'hF, 4'hF, 8'hE1, "first_capture");

        // Asynchronous assertion between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", prod, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (corners[i])
            cycle(corners[i].a, corners[i].b, corners[i].p, $sformatf("corner%0d", i));

        foreach (b2b[i])
            cycle(b2b[i].a, b2b[i].b, b2b[i].p, $sformatf("b2b%0d", i));

        // Operand change between edges: only the value at the edge counts.
        @(negedge clk);
        A = 4'd5;
        B = 4'd3;
        #2;
        A = 4'd6;
        @(posedge clk);
        #1;
        chk("midcycle", prod, 8'd18);
        #3;
        chk("stable", prod, 8'd18);

        // Reset pulse shorter than a cycle in the middle of a stream.
        cycle(4'd9, 4'd9, 8'd81, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid", prod, 8'h00);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_mid_hold", prod, 8'h00);
        cycle(4'd2, 4'd3, 8'd6, "post_rst");

        for (int unsigned a = 0; a < 16; a++) begin
            for (int unsigned b = 0; b < 16; b++) begin
                cycle(4'(a), 4'(b), 8'(a * b), $sformatf("exh_%0d_%0d", a, b));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
